// File: rtl/wconv_seq.sv
// Capture sequencer: forwards frame-aligned converter words as length-delimited AXI-Stream packets.
// Words that arrive while the output is stalled are dropped and flagged on ovf.
module wconv_seq #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_axis_tvalid,
  input  logic [255:0]     s_axis_tdata,
  output logic             m_axis_tvalid,
  output logic [255:0]     m_axis_tdata,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  input  logic             start,
  input  logic             abort,
  input  logic             trigger,
  input  logic             cont,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [2:0] {StIdle, StArmed, StAlign, StRun, StDone} state_e;

  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

  state_e state_q, state_d;

  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             trig_q;
  logic             s_vld_q;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic [255:0]     tdata_q, tdata_d;
  logic             ovf_q, ovf_d;

  logic             trig_rise;
  logic             frame_start;
  logic             start_ok;
  logic             word_in;
  logic [LEN_W-1:0] word_idx;
  logic             word_last;
  logic             out_free;

  assign trig_rise   = trigger & ~trig_q;
  assign frame_start = s_axis_tvalid & ~s_vld_q;
  assign start_ok    = start & (len != '0) & ((state_q == StIdle) | (state_q == StDone));

  // The frame-start word in ALIGN is word 0 and is forwarded in the same cycle.
  assign word_in   = ((state_q == StAlign) & frame_start) | ((state_q == StRun) & s_axis_tvalid);
  assign word_idx  = (state_q == StAlign) ? '0 : cnt_q;
  assign word_last = word_in & (word_idx == (len_q - LenOne));
  assign out_free  = m_axis_tready | ~tvalid_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      trig_q   <= 1'b0;
      s_vld_q  <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      trig_q   <= trigger;
      s_vld_q  <= s_axis_tvalid;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      ovf_q    <= ovf_d;
    end
  end

  // Payload and latched length carry no reset; they are qualified by tvalid and state.
  always_ff @(posedge aclk) begin
    len_q   <= len_d;
    tdata_q <= tdata_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: if (start_ok)    state_d = StArmed;
        StArmed:        if (trig_rise)   state_d = StAlign;
        StAlign:        if (frame_start) state_d = StRun;
        StRun:          state_d = StRun;
        default:        state_d = StIdle;
      endcase
      if (word_last) begin
        state_d = cont ? StArmed : StDone;
      end
    end
  end

  always_comb begin
    len_d    = len_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    if (m_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
    if (abort) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      cnt_d    = '0;
    end else begin
      if (start_ok) begin
        len_d = len;
        ovf_d = 1'b0;
        cnt_d = '0;
      end
      if (word_in) begin
        // Counter advances on every input word, accepted or dropped.
        cnt_d = word_last ? '0 : (word_idx + LenOne);
        if (out_free) begin
          tvalid_d = 1'b1;
          tdata_d  = s_axis_tdata;
          tlast_d  = word_last;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      StArmed, StAlign, StRun: busy = 1'b1;
      StDone:                  done = 1'b1;
      default:                 ;
    endcase
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign ovf           = ovf_q;

endmodule
